uart_rx_fifo: RTL and testbench

Memory-mapped UART receiver with a small receive FIFO. It deserializes 8N1 frames from the board RXD pin and queues received bytes. It exposes the head byte and status flags for the processor's IO read path, and pops a byte on a read strobe from the SOC IO decoder. It is the receive-side counterpart of the SOC's UART transmitter, running at the same baud rate on the same system clock.

---
 rtl/uart_rx_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small circular receive FIFO.
// A two-flop synchronizer feeds a mid-bit sampling FSM. Good bytes are
// queued, and the head byte plus status flags are exposed for the IO read path.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_AW     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rdStrobe,
    input  logic       clrErr,
    output logic [7:0] rdData,
    output logic       valid,
    output logic       full,
    output logic       overrun,
    output logic       frameErr
);

    localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF  = CPB / 2;
    localparam int TW    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [TW-1:0] TICK_RELOAD = TW'(CPB - 1);
    localparam logic [TW-1:0] TICK_HALF   = TW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (idle-high line, so both flops reset to 1)
    // ------------------------------------------------------------------
    logic rxMeta;
    logic rxS;

    // Two-flop synchronizer on the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxS    <= rxMeta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          stateReg, stateNext;
    logic [TW-1:0]   tickReg, tickNext;
    logic [2:0]      bitIdxReg, bitIdxNext;
    logic [7:0]      shregReg, shregNext;
    logic            pushReq;
    logic            frameErrEvt;
    logic            expired;

    assign expired = (tickReg == '0);

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= IDLE;
            tickReg   <= '0;
            bitIdxReg <= '0;
            shregReg  <= '0;
        end else begin
            stateReg  <= stateNext;
            tickReg   <= tickNext;
            bitIdxReg <= bitIdxNext;
            shregReg  <= shregNext;
        end
    end

    // Next-state logic: the bit timer runs only while a frame is in flight
    // and every expiry reloads a full bit period, so samples stay mid-bit.
    always_comb begin
        stateNext   = stateReg;
        tickNext    = tickReg;
        bitIdxNext  = bitIdxReg;
        shregNext   = shregReg;
        pushReq     = 1'b0;
        frameErrEvt = 1'b0;
        case (stateReg)
            IDLE: begin
                if (!rxS) begin
                    stateNext  = START;
                    tickNext   = TICK_HALF;
                    bitIdxNext = '0;
                end
            end
            START: begin
                if (expired) begin
                    tickNext  = TICK_RELOAD;
                    // A line already back high at mid-start is a glitch.
                    stateNext = rxS ? IDLE : DATA;
                end else begin
                    tickNext = tickReg - 1'b1;
                end
            end
            DATA: begin
                if (expired) begin
                    tickNext             = TICK_RELOAD;
                    shregNext[bitIdxReg] = rxS;
                    bitIdxNext           = bitIdxReg + 3'd1;
                    if (bitIdxReg == 3'd7) begin
                        stateNext = STOP;
                    end
                end else begin
                    tickNext = tickReg - 1'b1;
                end
            end
            STOP: begin
                if (expired) begin
                    tickNext = TICK_RELOAD;
                    if (rxS) begin
                        pushReq   = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        // Wait for the line to recover so a break reports once.
                        frameErrEvt = 1'b1;
                        stateNext   = WAITHI;
                    end
                end else begin
                    tickNext = tickReg - 1'b1;
                end
            end
            WAITHI: begin
                if (rxS) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [FIFO_AW:0] wrPtrReg;
    logic [FIFO_AW:0] rdPtrReg;
    logic [7:0]       mem [DEPTH];
    logic             empty;
    logic             fullInt;
    logic             doPop;
    logic             doPush;
    logic             dropByte;

    assign empty   = (wrPtrReg == rdPtrReg);
    assign fullInt = (wrPtrReg[FIFO_AW-1:0] == rdPtrReg[FIFO_AW-1:0]) &&
                     (wrPtrReg[FIFO_AW] != rdPtrReg[FIFO_AW]);

    // A pop on the same cycle frees the slot, so a push into a full FIFO
    // is only dropped when nobody is reading.
    assign doPop    = rdStrobe && !empty;
    assign doPush   = pushReq && (!fullInt || doPop);
    assign dropByte = pushReq && fullInt && !doPop;

    // Read and write pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
        end
    end

    // FIFO storage write; contents need no reset because empty masks rdData.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg[FIFO_AW-1:0]] <= shregReg;
        end
    end

    // Sticky error flags; a new error event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            if (dropByte) begin
                overrun <= 1'b1;
            end else if (clrErr) begin
                overrun <= 1'b0;
            end
            if (frameErrEvt) begin
                frameErr <= 1'b1;
            end else if (clrErr) begin
                frameErr <= 1'b0;
            end
        end
    end

    assign rdData = empty ? 8'h00 : mem[rdPtrReg[FIFO_AW-1:0]];
    assign valid  = !empty;
    assign full   = fullInt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at CPB=16, HALF=8.
// A table of single frames is applied in a loop, followed by hand-written
// sequences for the overflow, break, glitch, pop-on-push and reset cases.
module tb_uart_rx_fifo;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    // Edges from driving the start bit low to valid rising:
    // 2 synchronizer edges + HALF + 9*CPB + 1.
    localparam int RISE = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rdStrobe;
    logic       clrErr;
    logic [7:0] rdData;
    logic       valid;
    logic       full;
    logic       overrun;
    logic       frameErr;

    int nVec  = 0;
    int nMiss = 0;

    uart_rx_fifo #(
        .CLK_FREQ_HZ(16),
        .BAUD_RATE  (1),
        .FIFO_AW    (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rxd     (rxd),
        .rdStrobe(rdStrobe),
        .clrErr  (clrErr),
        .rdData  (rdData),
        .valid   (valid),
        .full    (full),
        .overrun (overrun),
        .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       expValid;
        logic [7:0] expData;
        logic       expFrameErr;
        int         expRise;
    } vec_t;

    vec_t vecs [6];

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Drive one 10-bit frame; pulse rdStrobe on edge popAt (counted from the
    // start-bit drive, -1 for none) and report the edge where valid rose.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                             input int popAt, output int riseAt);
        logic [9:0] fr;
        logic       prevValid;
        fr        = {stopBit, b, 1'b0};
        prevValid = valid;
        riseAt    = -1;
        for (int c = 0; c < 10 * CPB; c++) begin
            rxd      = fr[c / CPB];
            rdStrobe = ((c + 1) == popAt);
            step();
            if (riseAt < 0 && valid && !prevValid) begin
                riseAt = c + 1;
            end
            prevValid = valid;
        end
        rdStrobe = 1'b0;
        rxd      = 1'b1;
    endtask

    task automatic pop();
        rdStrobe = 1'b1;
        step();
        rdStrobe = 1'b0;
    endtask

    task automatic pulseClr();
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
    endtask

    initial begin
        int         rise;
        logic [7:0] expB;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, RISE};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, -1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, RISE};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, RISE};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, RISE};
        vecs[5] = '{8'h6E, 1'b1, 1'b1, 8'h6E, 1'b0, RISE};

        reset    = 1'b1;
        rxd      = 1'b1;
        rdStrobe = 1'b0;
        clrErr   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("reset rdData", int'(rdData), 0);
        check("reset valid", int'(valid), 0);
        check("reset full", int'(full), 0);
        check("reset overrun", int'(overrun), 0);
        check("reset frameErr", int'(frameErr), 0);

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            sendFrame(vecs[i].data, vecs[i].stopBit, -1, rise);
            repeat (4) step();
            check($sformatf("vec%0d rise", i), rise, vecs[i].expRise);
            check($sformatf("vec%0d valid", i), int'(valid), int'(vecs[i].expValid));
            check($sformatf("vec%0d rdData", i), int'(rdData), int'(vecs[i].expData));
            check($sformatf("vec%0d frameErr", i), int'(frameErr), int'(vecs[i].expFrameErr));
            pop();
            check($sformatf("vec%0d valid after pop", i), int'(valid), 0);
            check($sformatf("vec%0d rdData after pop", i), int'(rdData), 0);
            pulseClr();
            check($sformatf("vec%0d frameErr after clr", i), int'(frameErr), 0);
        end

        // Nine back-to-back frames, no reads.
        for (int k = 1; k <= 9; k++) begin
            sendFrame(8'(k), 1'b1, -1, rise);
            if (k == 8) begin
                check("b2b full after 8", int'(full), 1);
                check("b2b overrun after 8", int'(overrun), 0);
            end
        end
        check("b2b full after 9", int'(full), 1);
        check("b2b overrun after 9", int'(overrun), 1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("b2b read %0d", k), int'(rdData), k);
            pop();
        end
        check("b2b empty", int'(valid), 0);
        check("b2b full cleared", int'(full), 0);
        pop();
        check("b2b pop-on-empty rdData", int'(rdData), 0);
        pulseClr();
        check("b2b overrun cleared", int'(overrun), 0);

        // Bad stop bit followed by a held-low break, then a good frame.
        sendFrame(8'h3C, 1'b0, -1, rise);
        rxd = 1'b0;
        check("break frameErr", int'(frameErr), 1);
        pulseClr();
        repeat (5 * CPB) step();
        check("break single error", int'(frameErr), 0);
        check("break valid", int'(valid), 0);
        rxd = 1'b1;
        repeat (CPB) step();
        sendFrame(8'h55, 1'b1, -1, rise);
        check("break recovery rdData", int'(rdData), 8'h55);
        pop();
        check("break exactly one byte", int'(valid), 0);
        check("break no new frameErr", int'(frameErr), 0);

        // Four-cycle glitch while idle; the FSM must be idle again HALF+3
        // cycles after the drop so an immediate frame is received on time.
        rxd = 1'b0;
        repeat (4) step();
        rxd = 1'b1;
        repeat (HALF + 3 - 4) step();
        check("glitch no push", int'(valid), 0);
        check("glitch no error", int'(frameErr), 0);
        sendFrame(8'h96, 1'b1, -1, rise);
        check("glitch next rise", rise, RISE);
        check("glitch next rdData", int'(rdData), 8'h96);
        pop();

        // Full FIFO with rdStrobe on the same edge as the stop-bit push.
        for (int k = 0; k < 8; k++) begin
            sendFrame(8'h10 + 8'(k), 1'b1, -1, rise);
        end
        check("popPush full before", int'(full), 1);
        sendFrame(8'hEE, 1'b1, RISE, rise);
        check("popPush overrun", int'(overrun), 0);
        check("popPush full after", int'(full), 1);
        for (int k = 0; k < 8; k++) begin
            expB = (k == 7) ? 8'hEE : 8'h11 + 8'(k);
            check($sformatf("popPush read %0d", k), int'(rdData), int'(expB));
            pop();
        end
        check("popPush empty", int'(valid), 0);

        // Reset in the middle of data bit 4 with a byte queued and an error set.
        sendFrame(8'h3C, 1'b0, -1, rise);
        repeat (4) step();
        sendFrame(8'h5A, 1'b1, -1, rise);
        check("preReset valid", int'(valid), 1);
        check("preReset frameErr", int'(frameErr), 1);
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'hF0, 1'b0};
            for (int c = 0; c < 5 * CPB + HALF; c++) begin
                rxd = fr[c / CPB];
                step();
            end
        end
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("midReset valid", int'(valid), 0);
        check("midReset rdData", int'(rdData), 0);
        check("midReset full", int'(full), 0);
        check("midReset overrun", int'(overrun), 0);
        check("midReset frameErr", int'(frameErr), 0);
        repeat (2 * CPB) step();
        check("midReset no stray push", int'(valid), 0);
        sendFrame(8'hC3, 1'b1, -1, rise);
        check("postReset rise", rise, RISE);
        check("postReset rdData", int'(rdData), 8'hC3);
        check("postReset frameErr", int'(frameErr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
